i2c_slave: RTL and testbench



---
 rtl/i2c_slave_if.sv | 27 ++
 rtl/i2c_slave.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_if.sv
// I2C target bus-side bundle: pins, own-address config and byte-level handshake.
// The slave modport is used by i2c_slave; the master modport by whatever drives it.
interface i2c_slave_if;
  logic       en_i;
  logic [6:0] own_addr_i;
  logic       scl_i;
  logic       sda_i;
  logic       sda_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic [7:0] tx_data_i;
  logic       tx_req_o;
  logic       dir_o;
  logic       busy_o;
  logic       nack_o;
  logic       stop_o;

  modport slave (
    input  en_i, own_addr_i, scl_i, sda_i, tx_data_i,
    output sda_o, rx_data_o, rx_valid_o, tx_req_o, dir_o, busy_o, nack_o, stop_o
  );

  modport master (
    output en_i, own_addr_i, scl_i, sda_i, tx_data_i,
    input  sda_o, rx_data_o, rx_valid_o, tx_req_o, dir_o, busy_o, nack_o, stop_o
  );
endinterface

// File: rtl/i2c_slave.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address match, byte RX/TX.
// Optional glitch filter on both lines is built when I2C_SLAVE_GLITCH_FILTER_EN is defined.
module i2c_slave #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int FILTER_LEN = 4
) (
  input  logic        clk_i,
  input  logic        s_rst_i,
  i2c_slave_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_RX_DATA   = 3'd3,
    ST_RX_ACK    = 3'd4,
    ST_TX_DATA   = 3'd5,
    ST_TX_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_e;

  if (DATA_WIDTH != 8 || ADDR_WIDTH != 7 || FILTER_LEN < 1) begin : g_cfg_check
    $error("i2c_slave: only DATA_WIDTH=8, ADDR_WIDTH=7, FILTER_LEN>=1 are supported");
  end

  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       scl_c, sda_c;
  logic       scl_prev_q, scl_prev_d;
  logic       sda_prev_q, sda_prev_d;

  // Two-stage synchronizers and the edge-detect history registers.
  always_comb begin
    scl_sync_d = {scl_sync_q[0], bus.scl_i};
    sda_sync_d = {sda_sync_q[0], bus.sda_i};
    scl_prev_d = scl_c;
    sda_prev_d = sda_c;
  end

  // Synchronizer/edge flops reset high so an idle bus produces no spurious events.
  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  localparam int FCNT_W = $clog2(FILTER_LEN + 1);

  logic [FCNT_W-1:0] scl_fcnt_q, scl_fcnt_d, sda_fcnt_q, sda_fcnt_d;
  logic              scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;

  // Output follows the input only after FILTER_LEN consecutive differing samples.
  function automatic logic [FCNT_W:0] filt_step(input logic in_v, input logic out_v,
                                                input logic [FCNT_W-1:0] cnt_v);
    logic [FCNT_W:0] res;
    if (in_v == out_v) begin
      res = {out_v, {FCNT_W{1'b0}}};
    end else if (cnt_v == FCNT_W'(FILTER_LEN - 1)) begin
      res = {in_v, {FCNT_W{1'b0}}};
    end else begin
      res = {out_v, cnt_v + FCNT_W'(1)};
    end
    return res;
  endfunction

  // Glitch-filter next state for both lines.
  always_comb begin
    {scl_filt_d, scl_fcnt_d} = filt_step(scl_sync_q[1], scl_filt_q, scl_fcnt_q);
    {sda_filt_d, sda_fcnt_d} = filt_step(sda_sync_q[1], sda_filt_q, sda_fcnt_q);
  end

  // Glitch-filter registers.
  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
      scl_fcnt_q <= {FCNT_W{1'b0}};
      sda_fcnt_q <= {FCNT_W{1'b0}};
    end else begin
      scl_filt_q <= scl_filt_d;
      sda_filt_q <= sda_filt_d;
      scl_fcnt_q <= scl_fcnt_d;
      sda_fcnt_q <= sda_fcnt_d;
    end
  end

  assign scl_c = scl_filt_q;
  assign sda_c = sda_filt_q;
`else
  assign scl_c = scl_sync_q[1];
  assign sda_c = sda_sync_q[1];
`endif

  logic scl_rise, scl_fall, start_evt, stop_evt;
  assign scl_rise  = scl_c & ~scl_prev_q;
  assign scl_fall  = ~scl_c & scl_prev_q;
  assign start_evt = scl_c & scl_prev_q & ~sda_c & sda_prev_q;
  assign stop_evt  = scl_c & scl_prev_q & sda_c & ~sda_prev_q;

  state_e                state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] in_byte;
  logic                  byte_done_q, byte_done_d;
  logic                  sda_o_q, sda_o_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_req_q, tx_req_d;
  logic                  nack_q, nack_d;
  logic                  stop_q, stop_d;
  logic                  busy_q, busy_d;
  logic                  dir_q, dir_d;

  assign in_byte = {shift_q[DATA_WIDTH-2:0], sda_c};

  // Protocol FSM: START/STOP first, then per-state SCL edge handling.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_done_d = byte_done_q;
    sda_o_d     = sda_o_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    nack_d      = 1'b0;
    stop_d      = 1'b0;
    busy_d      = busy_q;
    dir_d       = dir_q;

    if (start_evt) begin
      state_d     = ST_ADDR;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      sda_o_d     = 1'b1;
      busy_d      = 1'b0;
    end else if (stop_evt) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      sda_o_d     = 1'b1;
      busy_d      = 1'b0;
      stop_d      = busy_q;
    end else begin
      case (state_q)
        ST_ADDR: begin
          // byte_done_q marks "address matched, ACK goes out at the next SCL fall".
          if (scl_rise && !byte_done_q) begin
            shift_d   = in_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (in_byte[DATA_WIDTH-1:DATA_WIDTH-ADDR_WIDTH] == bus.own_addr_i && bus.en_i) begin
                dir_d       = in_byte[0];
                busy_d      = 1'b1;
                byte_done_d = 1'b1;
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end else begin
            end
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            sda_o_d     = 1'b0;
            state_d     = ST_ADDR_ACK;
          end else begin
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            sda_o_d   = 1'b1;
            bit_cnt_d = 3'd0;
            if (dir_q) begin
              tx_req_d = 1'b1;
              state_d  = ST_TX_DATA;
            end else begin
              state_d = ST_RX_DATA;
            end
          end else begin
          end
        end
        ST_RX_DATA: begin
          if (scl_rise && !byte_done_q) begin
            shift_d   = in_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d   = in_byte;
              rx_valid_d  = 1'b1;
              byte_done_d = 1'b1;
            end else begin
            end
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            sda_o_d     = 1'b0;
            state_d     = ST_RX_ACK;
          end else begin
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            sda_o_d   = 1'b1;
            bit_cnt_d = 3'd0;
            state_d   = ST_RX_DATA;
          end else begin
          end
        end
        ST_TX_DATA: begin
          // tx_data_i is taken while tx_req_o is high; its MSB goes straight onto SDA.
          if (tx_req_q) begin
            shift_d   = bus.tx_data_i;
            sda_o_d   = bus.tx_data_i[DATA_WIDTH-1];
            bit_cnt_d = 3'd0;
          end else if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_o_d     = 1'b1;
              bit_cnt_d   = 3'd0;
              byte_done_d = 1'b0;
              state_d     = ST_TX_ACK;
            end else begin
              sda_o_d   = shift_q[DATA_WIDTH-2];
              shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
          end
        end
        ST_TX_ACK: begin
          if (scl_rise && !byte_done_q) begin
            if (sda_c) begin
              nack_d  = 1'b1;
              state_d = ST_WAIT_STOP;
            end else begin
              byte_done_d = 1'b1;
            end
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            tx_req_d    = 1'b1;
            state_d     = ST_TX_DATA;
          end else begin
          end
        end
        ST_IDLE, ST_WAIT_STOP: begin
          sda_o_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          sda_o_d = 1'b1;
        end
      endcase
    end
  end

  // FSM, shifter and registered outputs.
  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= {DATA_WIDTH{1'b0}};
      byte_done_q <= 1'b0;
      sda_o_q     <= 1'b1;
      rx_data_q   <= {DATA_WIDTH{1'b0}};
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      nack_q      <= 1'b0;
      stop_q      <= 1'b0;
      busy_q      <= 1'b0;
      dir_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_done_q <= byte_done_d;
      sda_o_q     <= sda_o_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      nack_q      <= nack_d;
      stop_q      <= stop_d;
      busy_q      <= busy_d;
      dir_q       <= dir_d;
    end
  end

  assign bus.sda_o      = sda_o_q;
  assign bus.rx_data_o  = rx_data_q;
  assign bus.rx_valid_o = rx_valid_q;
  assign bus.tx_req_o   = tx_req_q;
  assign bus.dir_o      = dir_q;
  assign bus.busy_o     = busy_q;
  assign bus.nack_o     = nack_q;
  assign bus.stop_o     = stop_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master, table of write transactions,
// hand-written read / repeated-START / reset / glitch sequences, RX/TX scoreboards.
module tb_i2c_slave;
  localparam int Q = 10;  // quarter SCL period in clk cycles

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic s_rst;
  logic scl_m, sda_m;
  i2c_slave_if bus ();

  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & bus.sda_o;

  i2c_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .FILTER_LEN(4)) dut (
    .clk_i  (clk),
    .s_rst_i(s_rst),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [7:0] rx_exp_q[$];
  logic [7:0] tx_exp_q[$];
  int   rx_cnt, txreq_cnt, nack_cnt, stop_cnt;
  logic sda_low_seen;

  // Output monitor: RX scoreboard compare, TX expectations captured on tx_req_o.
  always @(negedge clk) begin
    if (bus.rx_valid_o) begin
      rx_cnt++;
      if (rx_exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected: got 0x%0h, expected no rx_valid", bus.rx_data_o);
      end else begin
        check("rx_data", {24'd0, bus.rx_data_o}, {24'd0, rx_exp_q.pop_front()});
      end
    end
    if (bus.tx_req_o) begin
      txreq_cnt++;
      tx_exp_q.push_back(bus.tx_data_i);
    end
    if (bus.nack_o) nack_cnt++;
    if (bus.stop_o) stop_cnt++;
    if (!bus.sda_o) sda_low_seen = 1'b1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_counts();
    rx_cnt = 0; txreq_cnt = 0; nack_cnt = 0; stop_cnt = 0; sda_low_seen = 1'b0;
  endtask

  // Works both from idle and as a repeated START (SCL low).
  task automatic start_c();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic stop_c();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    s = bus.sda_i; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, input logic [7:0] next_tx, output logic [7:0] r);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(1'b1, r[i]);
    bus.tx_data_i = next_tx;
    clock_bit(mack, s);
  endtask

  task automatic check_tx(input string name, input logic [7:0] r);
    if (tx_exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected a tx_req_o before the byte", name, r);
    end else begin
      check(name, {24'd0, r}, {24'd0, tx_exp_q.pop_front()});
    end
  endtask

  typedef struct {
    logic [6:0] own;
    logic       en;
    logic [7:0] addr;
    logic [7:0] data;
    logic       exp_match;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic       ack, s;
    logic [7:0] r;

    vecs[0] = '{7'h50, 1'b1, 8'hA0, 8'hA5, 1'b1};  // own 0x50 write
    vecs[1] = '{7'h50, 1'b1, 8'hA2, 8'hFF, 1'b0};  // 0x51 mismatch
    vecs[2] = '{7'h50, 1'b0, 8'hA0, 8'h3C, 1'b0};  // disabled
    vecs[3] = '{7'h2A, 1'b1, 8'h54, 8'h00, 1'b1};
    vecs[4] = '{7'h7F, 1'b1, 8'hFE, 8'hFF, 1'b1};
    vecs[5] = '{7'h01, 1'b1, 8'h00, 8'h81, 1'b0};

    s_rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    bus.en_i = 1'b0; bus.own_addr_i = 7'h00; bus.tx_data_i = 8'h00;
    clr_counts();
    wait_clk(3);
    check("rst_sda_o", bus.sda_o, 1'b1);
    check("rst_rx_data", bus.rx_data_o, 8'h00);
    check("rst_rx_valid", bus.rx_valid_o, 1'b0);
    check("rst_tx_req", bus.tx_req_o, 1'b0);
    check("rst_nack", bus.nack_o, 1'b0);
    check("rst_stop", bus.stop_o, 1'b0);
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_dir", bus.dir_o, 1'b0);
    s_rst = 1'b0;
    wait_clk(5);

    for (int k = 0; k < 6; k++) begin
      bus.own_addr_i = vecs[k].own;
      bus.en_i       = vecs[k].en;
      clr_counts();
      start_c();
      write_byte(vecs[k].addr, ack);
      check($sformatf("v%0d_addr_ack", k), ack, !vecs[k].exp_match);
      check($sformatf("v%0d_busy", k), bus.busy_o, vecs[k].exp_match);
      if (vecs[k].exp_match) rx_exp_q.push_back(vecs[k].data);
      write_byte(vecs[k].data, ack);
      check($sformatf("v%0d_data_ack", k), ack, !vecs[k].exp_match);
      stop_c();
      wait_clk(5);
      check($sformatf("v%0d_rx_cnt", k), rx_cnt, {31'd0, vecs[k].exp_match});
      check($sformatf("v%0d_stop_cnt", k), stop_cnt, {31'd0, vecs[k].exp_match});
      check($sformatf("v%0d_busy_end", k), bus.busy_o, 1'b0);
      check($sformatf("v%0d_sda_driven", k), sda_low_seen, vecs[k].exp_match);
      check($sformatf("v%0d_rx_left", k), rx_exp_q.size(), 0);
    end

    // Two-byte read: ACK then NACK.
    bus.own_addr_i = 7'h50; bus.en_i = 1'b1; bus.tx_data_i = 8'h3C;
    clr_counts();
    start_c();
    write_byte(8'hA1, ack);
    check("rd_addr_ack", ack, 1'b0);
    check("rd_dir", bus.dir_o, 1'b1);
    check("rd_busy", bus.busy_o, 1'b1);
    read_byte(1'b0, 8'hC3, r);
    check("rd_byte0_val", r, 8'h3C);
    check_tx("rd_byte0_sb", r);
    read_byte(1'b1, 8'h00, r);
    check("rd_byte1_val", r, 8'hC3);
    check_tx("rd_byte1_sb", r);
    wait_clk(4);
    check("rd_nack_cnt", nack_cnt, 1);
    check("rd_txreq_cnt", txreq_cnt, 2);
    check("rd_sda_released", bus.sda_o, 1'b1);
    stop_c();
    wait_clk(5);
    check("rd_stop_cnt", stop_cnt, 1);
    check("rd_busy_end", bus.busy_o, 1'b0);

    // Repeated START: write 0x12 then read the same address.
    clr_counts();
    tx_exp_q.delete();
    bus.tx_data_i = 8'h5A;
    start_c();
    write_byte(8'hA0, ack);
    check("rs_addr0_ack", ack, 1'b0);
    rx_exp_q.push_back(8'h12);
    write_byte(8'h12, ack);
    check("rs_data_ack", ack, 1'b0);
    check("rs_dir0", bus.dir_o, 1'b0);
    start_c();
    check("rs_busy_drop", bus.busy_o, 1'b0);
    write_byte(8'hA1, ack);
    check("rs_addr1_ack", ack, 1'b0);
    check("rs_dir1", bus.dir_o, 1'b1);
    check("rs_txreq", txreq_cnt, 1);
    read_byte(1'b1, 8'h00, r);
    check_tx("rs_byte_sb", r);
    stop_c();
    wait_clk(5);
    check("rs_rx_cnt", rx_cnt, 1);
    check("rs_stop_cnt", stop_cnt, 1);

    // Reset while the slave is driving a data bit low.
    clr_counts();
    tx_exp_q.delete();
    bus.tx_data_i = 8'h00;
    start_c();
    write_byte(8'hA1, ack);
    check("rr_addr_ack", ack, 1'b0);
    for (int i = 0; i < 3; i++) clock_bit(1'b1, s);
    check("rr_bit_low", s, 1'b0);
    check("rr_sda_pre", bus.sda_o, 1'b0);
    s_rst = 1'b1;
    wait_clk(1);
    s_rst = 1'b0;
    check("rr_sda_rel", bus.sda_o, 1'b1);
    check("rr_busy", bus.busy_o, 1'b0);
    clr_counts();
    for (int i = 0; i < 6; i++) clock_bit(1'b1, s);
    stop_c();
    wait_clk(5);
    check("rr_idle_txreq", txreq_cnt, 0);
    check("rr_idle_sda", sda_low_seen, 1'b0);
    check("rr_idle_stop", stop_cnt, 0);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    // Short SDA pulses with SCL high must not become START/STOP; 8-cycle ones must.
    clr_counts();
    sda_m = 1'b0; wait_clk(2); sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
    write_byte(8'hA0, ack);
    check("gl_no_start_ack", ack, 1'b1);
    check("gl_no_start_busy", bus.busy_o, 1'b0);
    start_c();
    write_byte(8'hA0, ack);
    check("gl_addr_ack", ack, 1'b0);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(2); sda_m = 1'b0; wait_clk(Q);
    check("gl_no_stop_cnt", stop_cnt, 0);
    check("gl_no_stop_busy", bus.busy_o, 1'b1);
    sda_m = 1'b1; wait_clk(8); sda_m = 1'b0; wait_clk(Q);
    check("gl_stop_cnt", stop_cnt, 1);
    check("gl_stop_busy", bus.busy_o, 1'b0);
    scl_m = 1'b0; wait_clk(Q);
    stop_c();
    wait_clk(5);
    check("gl_final_stop_cnt", stop_cnt, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end
endmodule
